apb_bus_arbiter: RTL and testbench

APB_BUS_ARBITER -- requirements
Module: apb_bus_arbiter

---
 rtl/apb_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master.
// A granted transfer runs IDLE -> ISSUE (one-cycle request pulse) -> WAIT,
// and ends on the downstream ready pulse or on a wait-cycle timeout.
// A timeout completes the transfer towards the requester with err=1.
module apb_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  // requester 0 (CPU)
  input  logic        req0_transfer,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  // requester 1 (DMA)
  input  logic        req1_transfer,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  // downstream APB master
  output logic        transfer,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        ready,
  input  logic [31:0] rdata,
  // status
  output logic [1:0]  grant,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // The abort fires in the WAIT cycle whose count would reach TIMEOUT-1,
  // so the register is compared against one less than that.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 2);

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;   // 0 = req0, 1 = req1
  logic        write_reg, write_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [7:0]  timeout_cnt_reg, timeout_cnt_next;

  logic        done;       // downstream ready accepted this cycle
  logic        abort;      // wait budget exhausted this cycle
  logic        pick_req1;  // arbitration result while in IDLE

  // State and latched-request registers; reset clears everything.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg       <= IDLE;
      grant_reg       <= 2'b00;
      last_grant_reg  <= 1'b1;
      write_reg       <= 1'b0;
      addr_reg        <= 32'h0;
      wdata_reg       <= 32'h0;
      wait_cnt_reg    <= 8'h0;
      timeout_cnt_reg <= 8'h0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_grant_reg  <= last_grant_next;
      write_reg       <= write_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
    end
  end

  // Next-state logic: arbitration, wait counting, completion and timeout.
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    write_next       = write_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    wait_cnt_next    = wait_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    done             = 1'b0;
    abort            = 1'b0;
    // On a tie the requester that was not served last wins.
    pick_req1        = req1_transfer & (~req0_transfer | ~last_grant_reg);

    case (state_reg)
      IDLE: begin
        // A late downstream ready here is simply ignored.
        if (req0_transfer || req1_transfer) begin
          grant_next    = pick_req1 ? 2'b10 : 2'b01;
          write_next    = pick_req1 ? req1_write : req0_write;
          addr_next     = pick_req1 ? req1_addr  : req0_addr;
          wdata_next    = pick_req1 ? req1_wdata : req0_wdata;
          wait_cnt_next = 8'h0;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (ready) begin
          done = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (ready) begin
          done = 1'b1;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          abort = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (done || abort) begin
      state_next      = IDLE;
      grant_next      = 2'b00;
      last_grant_next = grant_reg[1];
    end

    if (abort && (timeout_cnt_reg != 8'hFF)) begin
      timeout_cnt_next = timeout_cnt_reg + 8'd1;
    end
  end

  // Per-requester response steering: only the granted side ever sees a response.
  logic [1:0]  ready_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata_vec [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign ready_vec[gi] = (done | abort) & grant_reg[gi];
      assign err_vec[gi]   = abort & grant_reg[gi];
      assign rdata_vec[gi] = (done & grant_reg[gi]) ? rdata : 32'h0;
    end
  endgenerate

  assign req0_ready  = ready_vec[0];
  assign req0_err    = err_vec[0];
  assign req0_rdata  = rdata_vec[0];
  assign req1_ready  = ready_vec[1];
  assign req1_err    = err_vec[1];
  assign req1_rdata  = rdata_vec[1];

  assign transfer    = (state_reg == ISSUE);
  assign write       = write_reg;
  assign addr        = addr_reg;
  assign wdata       = wdata_reg;
  assign grant       = grant_reg;
  assign timeout_cnt = timeout_cnt_reg;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter: single read, round-robin tie,
// timeout with late response, reset mid-WAIT and timeout-counter saturation.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_apb_bus_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic        req0_transfer, req0_write, req0_ready, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_transfer, req1_write, req1_ready, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        transfer, write, ready;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  grant;
  logic [7:0]  timeout_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  apb_bus_arbiter #(.TIMEOUT(16)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .req0_transfer (req0_transfer),
    .req0_write    (req0_write),
    .req0_addr     (req0_addr),
    .req0_wdata    (req0_wdata),
    .req0_ready    (req0_ready),
    .req0_err      (req0_err),
    .req0_rdata    (req0_rdata),
    .req1_transfer (req1_transfer),
    .req1_write    (req1_write),
    .req1_addr     (req1_addr),
    .req1_wdata    (req1_wdata),
    .req1_ready    (req1_ready),
    .req1_err      (req1_err),
    .req1_rdata    (req1_rdata),
    .transfer      (transfer),
    .write         (write),
    .addr          (addr),
    .wdata         (wdata),
    .ready         (ready),
    .rdata         (rdata),
    .grant         (grant),
    .timeout_cnt   (timeout_cnt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_rd;
    int          tmo;
    int          cycles;

    PRESET        = 1'b0;
    req0_transfer = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_transfer = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    ready         = 1'b0; rdata = 32'h0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge PCLK);
    #1;
    check("rst_grant",    32'(grant),       32'h0);
    check("rst_transfer", 32'(transfer),    32'h0);
    check("rst_addr",     addr,             32'h0);
    check("rst_tmo_cnt",  32'(timeout_cnt), 32'h0);
    check("rst_r0_ready", 32'(req0_ready),  32'h0);
    @(negedge PCLK);
    PRESET = 1'b1;

    // ---------------- single read by req0 ----------------
    @(negedge PCLK);
    req0_transfer = 1'b1; req0_write = 1'b0; req0_addr = 32'h1000_0004;
    #1;
    check("rd_idle_transfer", 32'(transfer), 32'h0);
    @(negedge PCLK); #1;                                   // ISSUE
    check("rd_issue_transfer", 32'(transfer), 32'h1);
    check("rd_issue_addr",     addr,           32'h1000_0004);
    check("rd_issue_write",    32'(write),     32'h0);
    check("rd_issue_grant",    32'(grant),     32'h1);
    @(negedge PCLK); #1;                                   // WAIT 1
    check("rd_wait_transfer", 32'(transfer),   32'h0);
    check("rd_wait_addr",     addr,            32'h1000_0004);
    check("rd_wait_r0_ready", 32'(req0_ready), 32'h0);
    @(negedge PCLK);                                       // WAIT 2, response
    ready = 1'b1; rdata = 32'h0000_00A5;
    #1;
    check("rd_r0_ready", 32'(req0_ready), 32'h1);
    check("rd_r0_rdata", req0_rdata,      32'h0000_00A5);
    check("rd_r0_err",   32'(req0_err),   32'h0);
    check("rd_r1_ready", 32'(req1_ready), 32'h0);
    check("rd_r1_rdata", req1_rdata,      32'h0);
    $display("txn single_read req0 addr=0x%08h rdata=0x%08h", addr, req0_rdata);
    @(negedge PCLK);
    ready = 1'b0; rdata = 32'h0; req0_transfer = 1'b0;
    #1;
    check("rd_done_grant",    32'(grant),      32'h0);
    check("rd_done_r0_ready", 32'(req0_ready), 32'h0);

    // ---------------- tie after reset: alternation ----------------
    @(negedge PCLK); PRESET = 1'b0;
    @(negedge PCLK); PRESET = 1'b1;
    @(negedge PCLK);
    req0_addr = 32'h0000_0100; req0_write = 1'b0; req0_wdata = 32'h0;
    req1_addr = 32'h0000_0200; req1_write = 1'b1; req1_wdata = 32'hDEAD_BEEF;
    req0_transfer = 1'b1; req1_transfer = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge PCLK); #1;                                 // ISSUE
      check("tie_grant",    32'(grant),    32'(exp_g));
      check("tie_transfer", 32'(transfer), 32'h1);
      check("tie_addr",     addr,          exp_g[0] ? 32'h0000_0100 : 32'h0000_0200);
      check("tie_write",    32'(write),    32'(exp_g[1]));
      @(negedge PCLK);                                     // WAIT 1: minimum latency
      exp_rd = 32'hA000_0000 + 32'(i);
      ready = 1'b1; rdata = exp_rd;
      #1;
      check("tie_r0_ready", 32'(req0_ready), 32'(exp_g[0]));
      check("tie_r1_ready", 32'(req1_ready), 32'(exp_g[1]));
      check("tie_r0_rdata", req0_rdata,      exp_g[0] ? exp_rd : 32'h0);
      check("tie_r1_rdata", req1_rdata,      exp_g[1] ? exp_rd : 32'h0);
      $display("txn tie %0d grant=%b rdata=0x%08h", i, grant, exp_rd);
      @(negedge PCLK);                                     // IDLE
      ready = 1'b0; rdata = 32'h0;
      #1;
      check("tie_idle_grant", 32'(grant), 32'h0);
    end
    req0_transfer = 1'b0; req1_transfer = 1'b0;

    // ---------------- timeout on req1, then a late response ----------------
    @(negedge PCLK);
    req1_transfer = 1'b1; req1_addr = 32'h0000_0300; req1_write = 1'b0;
    rdata = 32'hFFFF_FFFF;
    @(negedge PCLK); #1;                                   // ISSUE
    check("to_grant", 32'(grant), 32'h2);
    for (int n = 1; n <= 15; n++) begin
      @(negedge PCLK); #1;                                 // WAIT n
      if (n < 15) begin
        check("to_early_r1_ready", 32'(req1_ready), 32'h0);
      end else begin
        check("to_r1_ready", 32'(req1_ready),  32'h1);
        check("to_r1_err",   32'(req1_err),    32'h1);
        check("to_r1_rdata", req1_rdata,       32'h0);
        check("to_r0_ready", 32'(req0_ready),  32'h0);
        check("to_cnt_pre",  32'(timeout_cnt), 32'h0);
        req1_transfer = 1'b0;
      end
    end
    $display("txn timeout req1 after 15 wait cycles");
    @(negedge PCLK); #1;
    check("to_cnt_post",   32'(timeout_cnt), 32'h1);
    check("to_idle_grant", 32'(grant),       32'h0);
    @(negedge PCLK);
    ready = 1'b1; rdata = 32'h0000_0055;
    #1;
    check("late_r0_ready", 32'(req0_ready), 32'h0);
    check("late_r1_ready", 32'(req1_ready), 32'h0);
    check("late_r1_rdata", req1_rdata,      32'h0);
    @(negedge PCLK);
    ready = 1'b0; rdata = 32'h0;
    #1;
    check("late_grant",    32'(grant),    32'h0);
    check("late_transfer", 32'(transfer), 32'h0);
    $display("txn late_response ignored");

    // ---------------- reset in the middle of a req0 WAIT ----------------
    @(negedge PCLK);
    req0_transfer = 1'b1; req0_addr = 32'h0000_0400; req0_write = 1'b0;
    @(negedge PCLK); #1;                                   // ISSUE
    check("mr_grant", 32'(grant), 32'h1);
    @(negedge PCLK);                                       // WAIT 1
    @(negedge PCLK);                                       // WAIT 2, reset hits
    PRESET = 1'b0; ready = 1'b1; rdata = 32'h0000_0099;
    #1;
    check("mr_rst_grant",    32'(grant),       32'h0);
    check("mr_rst_transfer", 32'(transfer),    32'h0);
    check("mr_rst_r0_ready", 32'(req0_ready),  32'h0);
    check("mr_rst_r0_rdata", req0_rdata,       32'h0);
    check("mr_rst_tmo_cnt",  32'(timeout_cnt), 32'h0);
    check("mr_rst_addr",     addr,             32'h0);
    @(negedge PCLK);
    PRESET = 1'b1; ready = 1'b0; rdata = 32'h0;
    @(negedge PCLK); #1;                                   // ISSUE again
    check("mr_re_grant",    32'(grant),    32'h1);
    check("mr_re_transfer", 32'(transfer), 32'h1);
    check("mr_re_addr",     addr,          32'h0000_0400);
    @(negedge PCLK);
    ready = 1'b1; rdata = 32'h0000_0077;
    #1;
    check("mr_re_r0_ready", 32'(req0_ready), 32'h1);
    check("mr_re_r0_rdata", req0_rdata,      32'h0000_0077);
    check("mr_re_r0_err",   32'(req0_err),   32'h0);
    $display("txn reset_mid_wait then req0 read rdata=0x%08h", req0_rdata);
    @(negedge PCLK);
    ready = 1'b0; rdata = 32'h0; req0_transfer = 1'b0;
    #1;
    check("mr_done_grant", 32'(grant), 32'h0);

    // ---------------- timeout counter saturation ----------------
    @(negedge PCLK);
    req0_transfer = 1'b1; req0_addr = 32'h0000_0500;
    tmo = 0;
    cycles = 0;
    while (tmo < 260 && cycles < 6000) begin
      @(negedge PCLK); #1;
      cycles++;
      if (req0_ready && req0_err) begin
        tmo++;
        if (tmo == 255) check("sat_cnt_254", 32'(timeout_cnt), 32'd254);
        if (tmo == 260) check("sat_cnt_in",  32'(timeout_cnt), 32'd255);
      end
    end
    req0_transfer = 1'b0;
    check("sat_timeouts_seen", 32'(tmo), 32'd260);
    @(negedge PCLK); #1;
    check("sat_cnt_final", 32'(timeout_cnt), 32'd255);
    $display("txn saturation timeouts=%0d timeout_cnt=%0d", tmo, timeout_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
